// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: staged bring-up, load-use stalls, fetch-wait bubbles,
// mispredict flushes, and saturating stall/flush event counters.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             req,
  input  logic             reset,
  input  logic             instr_rvalid_in,
  input  logic             branch_mispredicted_in,
  input  logic [4:0]       rs1_unreg_in,
  input  logic             rs1_read_unreg_in,
  input  logic [4:0]       rs2_unreg_in,
  input  logic             rs2_read_unreg_in,
  input  logic [4:0]       ex_rd_in,
  input  logic             ex_rd_write_in,
  input  logic             ex_is_load_in,
  output logic [3:0]       stage_en_out,
  output logic             bubble_dec_out,
  output logic             bubble_ex_out,
  output logic             flush_out,
  output logic             stall_out,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] stall_cnt_out,
  output logic [CNT_W-1:0] flush_cnt_out
);

  localparam int unsigned FCNT_W     = 4;
  localparam int unsigned FILL_W     = 2;
  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [3:0] EN_ALL      = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;
  logic                stall_inc, flush_inc;
  logic                load_use;

  // Load-use hazard between the decode operands and a load in execute; x0 never matches
  assign load_use = ex_is_load_in & ex_rd_write_in & (ex_rd_in != 5'd0) &
                    ((rs1_read_unreg_in & (rs1_unreg_in == ex_rd_in)) |
                     (rs2_read_unreg_in & (rs2_unreg_in == ex_rd_in)));

  // Next-state and combinational stage controls
  always_comb begin
    state_d        = state_q;
    fill_d         = fill_q;
    fcnt_d         = fcnt_q;
    stage_en_out   = 4'b0000;
    bubble_dec_out = 1'b0;
    bubble_ex_out  = 1'b0;
    flush_out      = 1'b0;
    stall_out      = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FILL;
        fill_d  = '0;
      end
      FILL: begin
        case (fill_q)
          2'd0:    stage_en_out = 4'b0001;
          2'd1:    stage_en_out = 4'b0011;
          2'd2:    stage_en_out = 4'b0111;
          default: stage_en_out = 4'b1111;
        endcase
        fill_d = fill_q + FILL_W'(1);
        if (fill_q == 2'd3) state_d = RUN;
      end
      RUN: begin
        if (branch_mispredicted_in) begin
          stage_en_out   = EN_ALL;
          flush_out      = 1'b1;
          bubble_dec_out = 1'b1;
          bubble_ex_out  = 1'b1;
          fcnt_d         = FLUSH_LOAD;
          flush_inc      = 1'b1;
          state_d        = FLUSH;
        end else if (load_use) begin
          stage_en_out   = 4'b1100;
          stall_out      = 1'b1;
          bubble_ex_out  = 1'b1;
          stall_inc      = 1'b1;
        end else if (!instr_rvalid_in) begin
          stage_en_out   = EN_ALL;
          bubble_dec_out = 1'b1;
        end else begin
          stage_en_out   = EN_ALL;
        end
      end
      FLUSH: begin
        stage_en_out   = EN_ALL;
        bubble_dec_out = 1'b1;
        bubble_ex_out  = 1'b1;
        if (branch_mispredicted_in) begin
          flush_out = 1'b1;
          fcnt_d    = FLUSH_LOAD;
          flush_inc = 1'b1;
        end else if (fcnt_q == '0) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, fill index and flush countdown registers
  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fill_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Saturating event counters
  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign state_out     = 2'(state_q);
  assign stall_cnt_out = stall_cnt_q;
  assign flush_cnt_out = flush_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencer for the fetch/decode/execute/writeback pipeline.
- After reset it brings the stages up one per cycle, then runs the pipe.
- While running it resolves load-use hazards, instruction-fetch wait states and branch-mispredict flushes.
- It drives per-stage enables and bubble/flush strobes, and keeps saturating stall and flush event counters.

Parameters:
- FLUSH_CYCLES, 2: cycles spent in FLUSH after a mispredict; legal range 1..15.
- CNT_W, 16: width of the stall and flush event counters.

Ports:
- req  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous reset, active-low.
- instr_rvalid_in  in  1  fetch has valid instruction data this cycle.
- branch_mispredicted_in  in  1  execute reports a mispredicted branch.
- rs1_unreg_in  in  5  rs1 index of the instruction in decode.
- rs1_read_unreg_in  in  1  that instruction reads rs1.
- rs2_unreg_in  in  5  rs2 index of the instruction in decode.
- rs2_read_unreg_in  in  1  that instruction reads rs2.
- ex_rd_in  in  5  destination register of the instruction in execute.
- ex_rd_write_in  in  1  the instruction in execute writes rd.
- ex_is_load_in  in  1  the instruction in execute is a load.
- stage_en_out  out  4  stage enables: bit0 fetch, bit1 decode, bit2 execute, bit3 writeback.
- bubble_dec_out  out  1  insert a NOP into the decode input register.
- bubble_ex_out  out  1  insert a NOP into the execute input register.
- flush_out  out  1  single-cycle mispredict flush strobe.
- stall_out  out  1  load-use stall active.
- state_out  out  2  current state: 0 IDLE, 1 FILL, 2 RUN, 3 FLUSH.
- stall_cnt_out  out  CNT_W  number of load-use stall cycles, saturating.
- flush_cnt_out  out  CNT_W  number of mispredict events, saturating.

Behaviour:
- Reset (reset=0, asynchronous, effective immediately, including mid-operation):
  - state=IDLE, fill index=0, flush counter=0, both event counters=0.
  - Every output is 0.
- Output timing:
  - State, fill index, flush counter and event counters are registered.
  - stage_en_out, bubble_*, flush_out and stall_out are combinational from state and the current inputs.
- IDLE:
  - All outputs 0.
  - Moves to FILL on the first rising edge with reset=1.
- FILL:
  - stage_en_out takes 0001, 0011, 0111, 1111 on successive cycles.
  - On the edge that ends the 1111 cycle, state goes to RUN.
  - Total: 4 cycles in FILL.
  - Hazard, fetch-wait and mispredict inputs are ignored during FILL; no valid instructions are in flight.
- RUN, evaluated in priority order:
  1. Mispredict (branch_mispredicted_in=1):
     - flush_out=1, bubble_dec_out=1, bubble_ex_out=1, stage_en_out=1111.
     - Next state FLUSH with the flush counter loaded to FLUSH_CYCLES-1.
     - flush_cnt increments.
  2. Load-use hazard:
     - Condition: ex_is_load_in & ex_rd_write_in & ex_rd_in!=0 & ((rs1_read_unreg_in & rs1_unreg_in==ex_rd_in) | (rs2_read_unreg_in & rs2_unreg_in==ex_rd_in)).
     - Response: stall_out=1, stage_en_out=1100, bubble_ex_out=1.
     - stall_cnt increments; state stays RUN.
  3. Fetch wait (instr_rvalid_in=0):
     - stage_en_out=1111, bubble_dec_out=1.
     - No counter change.
  4. Otherwise: stage_en_out=1111, all strobes 0.
- Register x0: matches on register 0 never raise a hazard.
- FLUSH:
  - Outputs: stage_en_out=1111, bubble_dec_out=1, bubble_ex_out=1, flush_out=0, stall_out=0.
  - The flush counter decrements each cycle; when it reaches 0 at the edge, state goes to RUN.
  - Total FLUSH duration is exactly FLUSH_CYCLES cycles.
  - A new mispredict during FLUSH: flush_out=1, the flush counter reloads to FLUSH_CYCLES-1, flush_cnt increments.
  - Load-use and fetch-wait are ignored during FLUSH.
- Counters:
  - CNT_W-bit, saturate at all-ones; no wrap-around.
  - Cleared only by reset.
- Simultaneous mispredict and load-use: the mispredict wins; stall_out=0 and stall_cnt is unchanged.

Test Plan:
1. Bring-up: hold reset=0 for 3 cycles, then release. state_out shows 0 for 1 cycle, then 1 for 4 cycles (stage_en_out 0001, 0011, 0111, 1111), then 2. All counters are 0.
2. Load-use: in RUN drive ex_is_load_in=1, ex_rd_write_in=1, ex_rd_in=5, rs2_read_unreg_in=1, rs2_unreg_in=5 for 1 cycle. Required: stall_out=1, stage_en_out=1100, bubble_ex_out=1 that cycle; stall_cnt_out=1 afterwards. Repeat with ex_rd_in=0: no stall.
3. Mispredict with FLUSH_CYCLES=2: pulse branch_mispredicted_in in RUN. Required: flush_out=1 for 1 cycle, then state_out=3 for 2 cycles with both bubbles high, then back to RUN; flush_cnt_out=1.
4. Priority: in one RUN cycle assert both the mispredict and the load-use hazard. Required: flush_out=1, stall_out=0, stall_cnt_out unchanged. A second mispredict in the first FLUSH cycle extends FLUSH by 2 more cycles and sets flush_cnt_out=2.
5. Fetch wait: instr_rvalid_in=0 for 3 RUN cycles. Required: bubble_dec_out=1 and stage_en_out=1111 in each; no counter changes.
6. Reset mid-operation and saturation:
   - Assert reset=0 asynchronously during FLUSH. All outputs must read 0 before the next edge.
   - With CNT_W=2, hold a load-use hazard for 5 cycles. stall_cnt_out must stick at 3.
